// File: rtl/axis_arb_pkg.sv
// Shared types and constants for the AXI-Stream packet arbiter.
package axis_arb_pkg;

   localparam int MAX_PORTS = 4;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      PASS = 1'b1
   } arb_state_e;

   function automatic int src_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/axis_rr_grant.sv
// Combinational round-robin picker: first requester after the last-served index wins.
module axis_rr_grant #(
   parameter int N     = 2,
   parameter int SRC_W = 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [SRC_W-1:0] last_i,
   output logic             valid_o,
   output logic [SRC_W-1:0] grant_o
);

   int   dist_s;
   int   best_s;
   logic hit_s;

   // Distance 0 is the port right after last_i; the smallest requesting distance wins.
   always_comb begin
      valid_o = 1'b0;
      grant_o = '0;
      best_s  = N;
      dist_s  = 0;
      hit_s   = 1'b0;
      for (int i = 0; i < N; i++) begin
         dist_s  = (i + N - 1 - int'(last_i)) % N;
         hit_s   = req_i[i] && (dist_s < best_s);
         best_s  = hit_s ? dist_s : best_s;
         grant_o = hit_s ? SRC_W'(i) : grant_o;
         valid_o = valid_o | hit_s;
      end
   end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-level round-robin AXI-Stream arbiter with a registered master port.
// Optional AXIS_PACKET_ARBITER_SYNC_DISCARD_EN drops each port's first partial packet after reset.
module axis_packet_arbiter
   import axis_arb_pkg::*;
#(
   parameter int  AXIS_TDATA_WIDTH = 32,
   parameter int  NUM_PORTS        = 2,
   localparam int SRC_W            = src_width(NUM_PORTS)
) (
   input  logic                                  axis_aclk,
   input  logic                                  axis_areset,
   input  logic [NUM_PORTS*AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic [NUM_PORTS-1:0]                  s_axis_tvalid,
   input  logic [NUM_PORTS-1:0]                  s_axis_tlast,
   output logic [NUM_PORTS-1:0]                  s_axis_tready,
   output logic [AXIS_TDATA_WIDTH-1:0]           m_axis_tdata,
   output logic                                  m_axis_tvalid,
   output logic                                  m_axis_tlast,
   input  logic                                  m_axis_tready,
   output logic [SRC_W-1:0]                      m_axis_tuser
);

   localparam int W = AXIS_TDATA_WIDTH;

   if (NUM_PORTS < 2 || NUM_PORTS > MAX_PORTS) begin : g_bad_ports
      $error("axis_packet_arbiter: NUM_PORTS out of range");
   end

   arb_state_e           state_q, state_d;
   logic [SRC_W-1:0]     grant_q, grant_d;
   logic [SRC_W-1:0]     last_q, last_d;
   logic [NUM_PORTS-1:0] eligible_s;
   logic [NUM_PORTS-1:0] discard_ready_s;
   logic [NUM_PORTS-1:0] s_ready_s;
   logic                 rr_valid_s;
   logic [SRC_W-1:0]     rr_grant_s;
   logic [W-1:0]         sel_data_s;
   logic                 sel_valid_s;
   logic                 sel_last_s;
   logic                 pass_ready_s;
   logic                 accept_s;
   logic [W-1:0]         m_tdata_q;
   logic                 m_tvalid_q;
   logic                 m_tlast_q;
   logic [SRC_W-1:0]     m_tuser_q;

`ifdef AXIS_PACKET_ARBITER_SYNC_DISCARD_EN
   logic [NUM_PORTS-1:0] synced_q, synced_d;

   // Unsynced ports swallow beats until their first tlast handshake.
   always_comb begin
      discard_ready_s = ~synced_q & {NUM_PORTS{~axis_areset}};
      synced_d        = synced_q | (s_axis_tvalid & s_axis_tlast & discard_ready_s);
      eligible_s      = s_axis_tvalid & synced_q;
   end

   // Per-port sync tracking register.
   always_ff @(posedge axis_aclk or posedge axis_areset) begin
      if (axis_areset) begin
         synced_q <= '0;
      end else begin
         synced_q <= synced_d;
      end
   end
`else
   // Every port is eligible as soon as it presents a beat.
   always_comb begin
      discard_ready_s = '0;
      eligible_s      = s_axis_tvalid;
   end
`endif

   axis_rr_grant #(
      .N     (NUM_PORTS),
      .SRC_W (SRC_W)
   ) u_rr_grant (
      .req_i   (eligible_s),
      .last_i  (last_q),
      .valid_o (rr_valid_s),
      .grant_o (rr_grant_s)
   );

   // Route the granted slave's beat towards the output register.
   always_comb begin
      sel_data_s  = '0;
      sel_valid_s = 1'b0;
      sel_last_s  = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         sel_data_s  = (grant_q == SRC_W'(i)) ? s_axis_tdata[i*W +: W] : sel_data_s;
         sel_valid_s = (grant_q == SRC_W'(i)) ? s_axis_tvalid[i]      : sel_valid_s;
         sel_last_s  = (grant_q == SRC_W'(i)) ? s_axis_tlast[i]       : sel_last_s;
      end
   end

   assign pass_ready_s = ~m_tvalid_q | m_axis_tready;
   assign accept_s     = (state_q == PASS) & sel_valid_s & pass_ready_s;

   // FSM state, grant and last-served registers.
   always_ff @(posedge axis_aclk or posedge axis_areset) begin
      if (axis_areset) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= SRC_W'(NUM_PORTS - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   // Next state: grant locks in IDLE and is released only by an accepted tlast.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (rr_valid_s) begin
               state_d = PASS;
               grant_d = rr_grant_s;
            end else begin
               state_d = IDLE;
            end
         end
         PASS: begin
            if (accept_s && sel_last_s) begin
               state_d = IDLE;
               last_d  = grant_q;
            end else begin
               state_d = PASS;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Slave ready outputs: only the granted port sees the output-register space.
   always_comb begin
      s_ready_s = discard_ready_s;
      case (state_q)
         IDLE: begin
            s_ready_s = discard_ready_s;
         end
         PASS: begin
            for (int i = 0; i < NUM_PORTS; i++) begin
               s_ready_s[i] = discard_ready_s[i] | ((grant_q == SRC_W'(i)) & pass_ready_s);
            end
         end
         default: begin
            s_ready_s = discard_ready_s;
         end
      endcase
   end

   // Master output register; payload holds while stalled.
   always_ff @(posedge axis_aclk or posedge axis_areset) begin
      if (axis_areset) begin
         m_tvalid_q <= 1'b0;
         m_tlast_q  <= 1'b0;
         m_tdata_q  <= '0;
         m_tuser_q  <= '0;
      end else if (accept_s) begin
         m_tvalid_q <= 1'b1;
         m_tlast_q  <= sel_last_s;
         m_tdata_q  <= sel_data_s;
         m_tuser_q  <= grant_q;
      end else if (m_axis_tready) begin
         m_tvalid_q <= 1'b0;
      end
   end

   assign s_axis_tready = s_ready_s;
   assign m_axis_tdata  = m_tdata_q;
   assign m_axis_tvalid = m_tvalid_q;
   assign m_axis_tlast  = m_tlast_q;
   assign m_axis_tuser  = m_tuser_q;

endmodule

// File: doc/axis_packet_arbiter.md
AXIS_PACKET_ARBITER -- requirements
Module: axis_packet_arbiter

Interface
REQ-001 SHALL have parameter AXIS_TDATA_WIDTH, default 32, beat data width in bits.
REQ-002 SHALL have parameter NUM_PORTS, default 2, number of slave streams (legal 2..4).
REQ-003 SHALL have port axis_aclk  input  1  single clock for all logic.
REQ-004 SHALL have port axis_areset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port s_axis_tdata  input  NUM_PORTS*AXIS_TDATA_WIDTH  packed slave data; port i occupies slice [i*W +: W].
REQ-006 SHALL have ports s_axis_tvalid  input, s_axis_tlast  input, s_axis_tready  output, each NUM_PORTS wide, one bit per slave.
REQ-007 SHALL have ports m_axis_tdata  output  AXIS_TDATA_WIDTH, m_axis_tvalid  output  1, m_axis_tlast  output  1, m_axis_tready  input  1.
REQ-008 SHALL have port m_axis_tuser  output  SRC_W=max(1,clog2(NUM_PORTS))  index of the source port of the current beat.

Function
REQ-009 SHALL forward whole packets from one slave at a time to the master; beats of different packets SHALL never interleave.
REQ-010 SHALL implement FSM states IDLE and PASS.
- IDLE: if any eligible tvalid, latch grant = first eligible port after last-served index, round-robin; -> PASS next cycle; all s_axis_tready = 0.
- PASS: s_axis_tready[grant] = ~m_axis_tvalid | m_axis_tready; all other treadys 0.
- PASS: accepted beat with tlast -> IDLE; last-served <= grant.
REQ-011 SHALL register the master outputs: one output register, latency one cycle from slave handshake to m_axis_tvalid.
REQ-012 SHALL hold m_axis_tdata/tlast/tuser stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-013 SHALL clear m_axis_tvalid on master handshake unless a new beat is accepted in the same cycle.
REQ-014 SHALL sustain one beat per cycle within a packet; one idle arbitration cycle per packet boundary is permitted.
REQ-015 SHALL treat simultaneous requests strictly round-robin: after serving port k, priority order is k+1, ..., NUM_PORTS-1, 0, ..., k.
REQ-016 SHALL keep the grant unchanged when the granted port drops tvalid mid-packet; no timeout.
REQ-017 SHALL initialise last-served to NUM_PORTS-1 so that port 0 wins the first contest.

Reset
REQ-018 SHALL, while axis_areset=1, force state IDLE, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tuser=0, s_axis_tready=0, last-served=NUM_PORTS-1.
REQ-019 SHALL, on reset asserted mid-packet, drop the held beat; after release, behave as after power-up.

Configuration
REQ-020 SHALL honour macro AXIS_PACKET_ARBITER_SYNC_DISCARD_EN.
- Defined: after reset each port is unsynced; beats from an unsynced port are accepted and discarded (tready=1, nothing forwarded, no grant) up to and including its first tlast; the port is then synced and eligible.
- Undefined: all ports are eligible immediately after reset; no beats are discarded.

Structure
REQ-021 SHALL place the FSM state enum (IDLE, PASS) and constant MAX_PORTS=4 in shared package axis_arb_pkg.
REQ-022 SHALL implement the round-robin selection in sub-module axis_rr_grant: inputs request vector and last-served index; outputs valid and grant index; purely combinational.

Verification
REQ-023 Bench SHALL cover, with NUM_PORTS=2, W=32, macro undefined:
- Port0 sends 3-beat packet 11,12,13 alone -> master emits 11,12,13, tlast on 13, tuser=0, first beat two cycles after s_tvalid.
- Both ports valid at once; port0 sends 21..23, port1 sends 31..33 -> master emits 21,22,23 then 31,32,33, no interleave, tuser 0 then 1.
- m_axis_tready held 0 for 5 cycles mid-packet -> output beat held stable, granted tready=0, no beat lost or duplicated.
- Port1 streams 1-beat packets 0..9 back-to-back while port0 stays idle -> all 10 beats output in order, tlast=1 on each, tuser=1.
REQ-024 Bench SHALL, with the macro defined, drive partial packet 2,3(tlast) then full packet 11,12,13 on port0 -> 2 and 3 are discarded; master emits only 11,12,13.
REQ-025 Bench SHALL assert axis_areset during beat 2 of a packet -> m_axis_tvalid=0 immediately; after release the next full packet is forwarded intact from port 0.
